// File: rtl/layer4_sched_pkg.sv
// Shared types and width helpers for the layer-4 fully-connected sequencer.
// The state encoding is shared so other blocks can decode sequencer phases consistently.
package layer4_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACCUM,
    FLUSH,
    RELU,
    WAIT,
    DRAIN,
    DONE
  } state_e;

  // Address/counter width that never collapses to zero bits for depth-1 ranges.
  function automatic int clog2w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IN_LEN_DEF  = 64;
  localparam int OUT_LEN_DEF = 32;
  localparam int MAC_NUM_DEF = 16;
  localparam int NGRP_DEF    = OUT_LEN_DEF / MAC_NUM_DEF;
  localparam int XAW_DEF     = clog2w(IN_LEN_DEF);
  localparam int WAW_DEF     = clog2w(NGRP_DEF * IN_LEN_DEF);
  localparam int TAW_DEF     = clog2w(OUT_LEN_DEF);

endpackage

// File: rtl/layer4_sched_delay.sv
// Fixed-depth 1-bit shift register; aligns the MAC enable with data returning from the BRAMs.
module sched_delay_line #(
  parameter int DEPTH = 1
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] r_sh;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_sh <= '0;
    end else begin
      r_sh[0] <= d_i;
      for (int n = 1; n < DEPTH; n++) begin
        r_sh[n] <= r_sh[n-1];
      end
    end
  end

  assign q_o = r_sh[DEPTH-1];

endmodule

// File: rtl/layer4_sched.sv
// Layer-4 FC sequencer: streams activations/weights into the 16-lane PU per output group,
// then drains the serialized results into the layer-4 temp BRAM.
module layer4_sched
  import layer4_sched_pkg::*;
#(
  parameter  int IN_LEN  = 64,
  parameter  int OUT_LEN = 32,
  parameter  int MAC_NUM = 16,
  parameter  int RD_LAT  = 1,
  parameter  int PU_LAT  = 2,
  localparam int NGRP    = OUT_LEN / MAC_NUM,
  localparam int XAW     = clog2w(IN_LEN),
  localparam int WAW     = clog2w(NGRP * IN_LEN),
  localparam int TAW     = clog2w(OUT_LEN)
) (
  input  logic           clk_i,
  input  logic           rstn_i,
  input  logic           start_i,
  output logic           busy_o,
  output logic           done_o,
  output logic           x_en_o,
  output logic [XAW-1:0] x_addr_o,
  output logic           w_en_o,
  output logic [WAW-1:0] w_addr_o,
  output logic           mac_clear_o,
  output logic           mac_en_o,
  output logic           relu_en_o,
  output logic           temp_start_o,
  output logic           temp_wr_en_o,
  output logic [TAW-1:0] temp_wr_addr_o,
  output logic           layer3_temp_clear_o
);

  localparam int GW = clog2w(NGRP);
  localparam int KW = clog2w(MAC_NUM);
  localparam int DW = clog2w((RD_LAT > PU_LAT) ? RD_LAT : PU_LAT);

  localparam logic [XAW-1:0] I_LAST   = XAW'(IN_LEN - 1);
  localparam logic [GW-1:0]  G_LAST   = GW'(NGRP - 1);
  localparam logic [KW-1:0]  K_LAST   = KW'(MAC_NUM - 1);
  localparam logic [DW-1:0]  D_FLUSH  = DW'(RD_LAT - 1);
  localparam logic [DW-1:0]  D_WAIT   = DW'(PU_LAT - 1);
  localparam logic [WAW-1:0] IN_LEN_W = WAW'(IN_LEN);
  localparam logic [TAW-1:0] MAC_W    = TAW'(MAC_NUM);

  state_e         r_state, w_state_nxt;
  logic [GW-1:0]  r_g, w_g_nxt;
  logic [XAW-1:0] r_i, w_i_nxt;
  logic [KW-1:0]  r_k, w_k_nxt;
  logic [DW-1:0]  r_d, w_d_nxt;

  logic           r_busy, r_done, r_x_en, r_mac_clear, r_relu, r_twe;
  logic [XAW-1:0] r_x_addr, w_x_addr_nxt;
  logic [WAW-1:0] r_w_addr, w_w_addr_nxt;
  logic [TAW-1:0] r_t_addr, w_t_addr_nxt;
  logic           w_busy_nxt, w_done_nxt, w_x_en_nxt, w_clear_nxt, w_relu_nxt, w_twe_nxt;
  logic           w_mac_en;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state     <= IDLE;
      r_g         <= '0;
      r_i         <= '0;
      r_k         <= '0;
      r_d         <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_x_en      <= 1'b0;
      r_mac_clear <= 1'b0;
      r_relu      <= 1'b0;
      r_twe       <= 1'b0;
      r_x_addr    <= '0;
      r_w_addr    <= '0;
      r_t_addr    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_g         <= w_g_nxt;
      r_i         <= w_i_nxt;
      r_k         <= w_k_nxt;
      r_d         <= w_d_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_x_en      <= w_x_en_nxt;
      r_mac_clear <= w_clear_nxt;
      r_relu      <= w_relu_nxt;
      r_twe       <= w_twe_nxt;
      r_x_addr    <= w_x_addr_nxt;
      r_w_addr    <= w_w_addr_nxt;
      r_t_addr    <= w_t_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_g_nxt     = r_g;
    w_i_nxt     = r_i;
    w_k_nxt     = r_k;
    w_d_nxt     = r_d;
    case (r_state)
      IDLE: begin
        w_g_nxt = '0;
        if (start_i) w_state_nxt = CLEAR;
      end
      CLEAR: begin
        w_i_nxt     = '0;
        w_state_nxt = ACCUM;
      end
      ACCUM: begin
        if (r_i == I_LAST) begin
          w_d_nxt     = '0;
          w_state_nxt = FLUSH;
        end else begin
          w_i_nxt = r_i + XAW'(1);
        end
      end
      FLUSH: begin
        if (r_d == D_FLUSH) w_state_nxt = RELU;
        else                w_d_nxt     = r_d + DW'(1);
      end
      RELU: begin
        w_d_nxt     = '0;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (r_d == D_WAIT) begin
          w_k_nxt     = '0;
          w_state_nxt = DRAIN;
        end else begin
          w_d_nxt = r_d + DW'(1);
        end
      end
      DRAIN: begin
        if (r_k != K_LAST) begin
          w_k_nxt = r_k + KW'(1);
        end else if (r_g < G_LAST) begin
          w_g_nxt     = r_g + GW'(1);
          w_state_nxt = CLEAR;
        end else begin
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Strobes are decoded from the upcoming state and registered, so they line up with r_state.
  always_comb begin
    w_busy_nxt   = (w_state_nxt != IDLE);
    w_done_nxt   = (w_state_nxt == DONE);
    w_x_en_nxt   = (w_state_nxt == ACCUM);
    w_clear_nxt  = (w_state_nxt == CLEAR);
    w_relu_nxt   = (w_state_nxt == RELU);
    w_twe_nxt    = (w_state_nxt == DRAIN);
    w_x_addr_nxt = r_x_addr;
    w_w_addr_nxt = r_w_addr;
    w_t_addr_nxt = r_t_addr;
    if (w_x_en_nxt) begin
      w_x_addr_nxt = w_i_nxt;
      w_w_addr_nxt = WAW'(w_g_nxt) * IN_LEN_W + WAW'(w_i_nxt);
    end
    if (w_twe_nxt) begin
      w_t_addr_nxt = TAW'(w_g_nxt) * MAC_W + TAW'(w_k_nxt);
    end
  end

  sched_delay_line #(
    .DEPTH (RD_LAT)
  ) u_mac_en_dly (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .d_i    (r_x_en),
    .q_o    (w_mac_en)
  );

  assign busy_o              = r_busy;
  assign done_o              = r_done;
  assign x_en_o              = r_x_en;
  assign x_addr_o            = r_x_addr;
  assign w_en_o              = r_x_en;
  assign w_addr_o            = r_w_addr;
  assign mac_clear_o         = r_mac_clear;
  assign mac_en_o            = w_mac_en;
  assign relu_en_o           = r_relu;
  assign temp_start_o        = r_relu;
  assign temp_wr_en_o        = r_twe;
  assign temp_wr_addr_o      = r_t_addr;
  assign layer3_temp_clear_o = r_done;

endmodule

// File: doc/layer4_sched.md
Name: layer4_sched

Overview:
- Sequencer for the layer-4 fully-connected stage.
- Drives the layer-3 activation buffer read port, the layer-4 weight buffer read port, and the 16-lane PU control strobes (mac_clear, mac_en, relu_en, temp_start).
- Writes the serialized PU results into the layer-4 temp BRAM.
- Processes OUT_LEN outputs in groups of MAC_NUM, then pulses done and clears the layer-3 temp buffer for the next image.

Parameters:
- IN_LEN, 64: activations per output neuron (layer-3 buffer depth used).
- OUT_LEN, 32: layer-4 outputs; must be a multiple of MAC_NUM.
- MAC_NUM, 16: parallel MAC lanes in the PU (one weight word = MAC_NUM bytes).
- RD_LAT, 1: BRAM read latency, in cycles, from en/addr to data.
- PU_LAT, 2: cycles from temp_start_o to the first serialized PU result on pu_data.
- Localparams:
  - NGRP = OUT_LEN/MAC_NUM
  - XAW = clog2(IN_LEN)
  - WAW = clog2(NGRP*IN_LEN)
  - TAW = clog2(OUT_LEN)

Ports:
- clk_i  in  1  system clock
- rstn_i  in  1  asynchronous active-low reset
- start_i  in  1  start pulse; sampled only in IDLE
- busy_o  out  1  high from the cycle after start is accepted until the cycle done_o is asserted, inclusive
- done_o  out  1  one-cycle pulse at end of all groups
- x_en_o  out  1  layer-3 buffer read enable
- x_addr_o  out  XAW  layer-3 buffer read address
- w_en_o  out  1  weight buffer read enable
- w_addr_o  out  WAW  weight buffer read address
- mac_clear_o  out  1  clears PU accumulators
- mac_en_o  out  1  PU accumulate enable, aligned to returning BRAM data
- relu_en_o  out  1  PU ReLU/requantize strobe
- temp_start_o  out  1  starts PU serialization of MAC_NUM results
- temp_wr_en_o  out  1  temp BRAM write enable
- temp_wr_addr_o  out  TAW  temp BRAM write address
- layer3_temp_clear_o  out  1  one-cycle clear of the layer-3 temp buffer

Behaviour:
- Reset: asynchronous, active-low. State=IDLE; all outputs 0; group counter g, input counter i, and drain counter k = 0.
  - Reset mid-operation aborts immediately; there is no partial done_o.
- Counters: g is 0..NGRP-1; i is 0..IN_LEN-1; k is 0..MAC_NUM-1.
- FSM:
  - IDLE: start_i=1 -> CLEAR, g=0. start_i while not IDLE is ignored (not queued).
  - CLEAR (1 cycle): mac_clear_o=1; i=0 -> ACCUM.
  - ACCUM (IN_LEN cycles):
    - x_en_o=w_en_o=1, x_addr_o=i, w_addr_o=g*IN_LEN+i.
    - i increments each cycle; at i=IN_LEN-1 -> FLUSH.
  - mac_en_o is x_en_o delayed by exactly RD_LAT cycles (shift register), independent of state.
  - FLUSH (RD_LAT cycles): enables low; waits for the last mac_en_o -> RELU.
  - RELU (1 cycle): relu_en_o=1 and temp_start_o=1 -> WAIT.
  - WAIT (PU_LAT cycles) -> DRAIN, k=0.
  - DRAIN (MAC_NUM cycles):
    - temp_wr_en_o=1, temp_wr_addr_o=g*MAC_NUM+k.
    - After k=MAC_NUM-1: if g<NGRP-1 then g++ -> CLEAR, else -> DONE.
  - DONE (1 cycle): done_o=1, layer3_temp_clear_o=1 -> IDLE.
- All strobes are registered outputs (no combinational paths from inputs).
- Latency with defaults: per group 1+64+1+1+2+16 = 85 cycles. start accepted at cycle 0 -> done_o at cycle 171.
- Addresses hold their last value when their enable is low; checkers must ignore addresses when enables are low.
- Boundary conditions:
  - Last group wraps g to 0 only in IDLE.
  - Weight address tops out at NGRP*IN_LEN-1 = 127.
  - Temp address tops out at OUT_LEN-1 = 31.
  - No write occurs outside DRAIN.

Decomposition:
- Shared package: state enum (IDLE, CLEAR, ACCUM, FLUSH, RELU, WAIT, DRAIN, DONE) and the clog2-derived width constants.
- One sub-module, sched_delay_line: parameterized RD_LAT-deep 1-bit shift register with async reset, producing mac_en_o from x_en_o.

Test Plan:
- Reset, then a start pulse -> busy_o rises next cycle. Check:
  - mac_clear_o at cycle 1.
  - x_addr 0..63 and w_addr 0..63 over cycles 2..65.
  - mac_en_o over cycles 3..66.
  - done_o at cycle 171.
- Full-run scoreboard, checking exactly these totals:
  - 128 w_en cycles covering w_addr 0..127, each address once.
  - 32 temp writes covering addresses 0..31, each once, in order.
  - 2 relu_en pulses and 2 temp_start pulses.
  - 1 layer3_temp_clear pulse.
- start_i held high for the entire run -> exactly one run. A second start in the cycle after done_o launches a new run.
- rstn_i asserted at cycle 40 (mid-ACCUM) -> all outputs 0 asynchronously, no done_o. A fresh start restarts from w_addr 0.
- Parameter override IN_LEN=8, OUT_LEN=16, MAC_NUM=16, RD_LAT=2 -> single group. Expect:
  - mac_en_o lags x_en_o by 2 cycles.
  - done_o at cycle 1+8+2+1+2+16+1 = 31.
- Assertions held throughout:
  - mac_en_o never high while mac_clear_o is high.
  - temp_wr_en_o never high outside DRAIN.
  - busy_o low exactly in IDLE.
